alu_hs: RTL and testbench

- Parametrised, registered successor to the single-cycle 2-op-bit datapath ALU.
- Widens the opcode to 4 bits, adding carry-in ops, reverse subtract, EOR/BIC/MOV/MVN and an optional iterative multiply.
- Wraps the datapath in a valid/ready handshake so the pipeline control can stall on multi-cycle ops.
- Sits between the register-read stage and the writeback/flags register of the ARM core.

---
 rtl/alu_hs.sv | 170 +++++++++++++++++
 tb/tb_alu_hs.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_hs.sv
// alu_hs: registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops register their result and flags at the accept edge. MUL is an iterative
// shift-add multiply that consumes one multiplier bit per edge.
// Optional feature macro: ALU_HS_MUL_EN enables opcode 1011 (MUL). When the macro is
// undefined, 1011 behaves as a reserved opcode.
module alu_hs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Src_A,
  input  logic [WIDTH-1:0] Src_B,
  input  logic [3:0]       ALUControl,
  input  logic             Carry_In,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             accept;

  // Adder operands after inversion; shared by all carry-producing ops.
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_c, is_arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_sc;
  logic [3:0]       flags_sc;

`ifdef ALU_HS_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  logic [CntW-1:0]  mul_cnt_q, mul_cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] mul_b_q, mul_b_d;   // multiplier, shifted right each step
  logic [WIDTH-1:0] mul_acc_q, mul_acc_d;
`endif

  assign Out_Valid = (state_q == StDone);
  assign In_Ready  = (state_q == StIdle) | ((state_q == StDone) & Out_Ready);
  assign accept    = In_Valid & In_Ready;
  assign ALUResult = res_q;
  assign ALUFlags  = flags_q;

  // Select adder operands and carry-in for the arithmetic opcodes.
  always_comb begin
    add_x    = Src_A;
    add_y    = Src_B;
    add_c    = 1'b0;
    is_arith = 1'b0;
    case (ALUControl)
      4'b0000: is_arith = 1'b1;
      4'b0001: begin add_y = ~Src_B; add_c = 1'b1;     is_arith = 1'b1; end
      4'b0110: begin add_c = Carry_In;                 is_arith = 1'b1; end
      4'b0111: begin add_y = ~Src_B; add_c = Carry_In; is_arith = 1'b1; end
      4'b1000: begin add_x = Src_B; add_y = ~Src_A; add_c = 1'b1; is_arith = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_c};

  // Single-cycle result and flags; reserved (and MUL here) yield zero.
  always_comb begin
    res_sc = '0;
    case (ALUControl)
      4'b0000, 4'b0001, 4'b0110, 4'b0111, 4'b1000: res_sc = sum[WIDTH-1:0];
      4'b0010: res_sc = Src_A & Src_B;
      4'b0011: res_sc = Src_A | Src_B;
      4'b0100: res_sc = Src_A ^ Src_B;
      4'b0101: res_sc = Src_A & ~Src_B;
      4'b1001: res_sc = Src_B;
      4'b1010: res_sc = ~Src_B;
      default: res_sc = '0;
    endcase
    flags_sc[3] = res_sc[WIDTH-1];
    flags_sc[2] = (res_sc == '0);
    flags_sc[1] = is_arith & sum[WIDTH];
    flags_sc[0] = is_arith & (add_x[WIDTH-1] == add_y[WIDTH-1]) &
                  (sum[WIDTH-1] != add_x[WIDTH-1]);
  end

  // Handshake FSM, result registers and multiply iteration.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flags_d = flags_q;
`ifdef ALU_HS_MUL_EN
    mul_cnt_d = mul_cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_acc_d = mul_acc_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
`ifdef ALU_HS_MUL_EN
          if (ALUControl == 4'b1011) begin
            state_d   = StMul;
            mul_cnt_d = '0;
            mul_a_d   = Src_A;
            mul_b_d   = Src_B;
            mul_acc_d = '0;
          end else begin
            state_d = StDone;
            res_d   = res_sc;
            flags_d = flags_sc;
          end
`else
          state_d = StDone;
          res_d   = res_sc;
          flags_d = flags_sc;
`endif
        end else if (state_q == StDone && Out_Ready) begin
          state_d = StIdle;
        end
      end
`ifdef ALU_HS_MUL_EN
      StMul: begin
        // WIDTH iterations, then one more edge to publish the product.
        if (mul_cnt_q == CntW'(WIDTH)) begin
          state_d = StDone;
          res_d   = mul_acc_q;
          flags_d = {mul_acc_q[WIDTH-1], (mul_acc_q == '0), 2'b00};
        end else begin
          if (mul_b_q[0]) mul_acc_d = mul_acc_q + mul_a_q;
          mul_a_d   = mul_a_q << 1;
          mul_b_d   = mul_b_q >> 1;
          mul_cnt_d = mul_cnt_q + CntW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StIdle;
      res_q     <= '0;
      flags_q   <= '0;
`ifdef ALU_HS_MUL_EN
      mul_cnt_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_acc_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
`ifdef ALU_HS_MUL_EN
      mul_cnt_q <= mul_cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_acc_q <= mul_acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: directed-vector self-checking bench for alu_hs (WIDTH=32).
module tb_alu_hs;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Src_A, Src_B;
  logic [3:0]  ALUControl;
  logic        Carry_In;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_hs #(.WIDTH(32)) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Src_A      (Src_A),
    .Src_B      (Src_B),
    .ALUControl (ALUControl),
    .Carry_In   (Carry_In),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op, accept it, then check result one cycle later.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic [31:0] er,
                        input logic [3:0] ef);
    @(negedge CLK);
    ALUControl = op; Src_A = a; Src_B = b; Carry_In = cin; In_Valid = 1'b1;
    @(posedge CLK);
    #1 In_Valid = 1'b0;
    @(negedge CLK);
    check({tag, "_valid"}, {63'd0, Out_Valid}, 64'd1);
    check({tag, "_res"}, {32'd0, ALUResult}, {32'd0, er});
    check({tag, "_flags"}, {60'd0, ALUFlags}, {60'd0, ef});
  endtask

  logic [3:0]  bb_op  [4];
  logic [31:0] bb_a   [4];
  logic [31:0] bb_b   [4];
  logic [31:0] bb_exp [4];
  int          n;
  logic        seen;

  initial begin
    RESET_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    Src_A = '0; Src_B = '0; ALUControl = '0; Carry_In = 1'b0;
    #3;
    check("rst_valid", {63'd0, Out_Valid}, 64'd0);
    check("rst_res", {32'd0, ALUResult}, 64'd0);
    check("rst_flags", {60'd0, ALUFlags}, 64'd0);
    #9 RESET_n = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", {63'd0, In_Ready}, 64'd1);
    check("rst_out_valid", {63'd0, Out_Valid}, 64'd0);

    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1001);
    run_op("sub_zero", 4'b0001, 32'd5, 32'd5, 1'b0, 32'h0, 4'b0110);
    run_op("sub_borrow", 4'b0001, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    run_op("rsb", 4'b1000, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    run_op("adc", 4'b0110, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h0, 4'b0110);
    run_op("sbc", 4'b0111, 32'd3, 32'd1, 1'b0, 32'd1, 4'b0010);
    run_op("and", 4'b0010, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'h0F00_0F00, 4'b0000);
    run_op("orr", 4'b0011, 32'h8000_0000, 32'h1, 1'b0, 32'h8000_0001, 4'b1000);
    run_op("bic", 4'b0101, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'hFFFF_0000, 4'b1000);
    run_op("mov", 4'b1001, 32'h1234_5678, 32'hCAFE_0000, 1'b1, 32'hCAFE_0000, 4'b1000);
    run_op("mvn", 4'b1010, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 4'b0100);
    run_op("rsvd", 4'b1100, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 4'b0100);
`ifndef ALU_HS_MUL_EN
    run_op("mul_off", 4'b1011, 32'h0001_0003, 32'h0002_0005, 1'b0, 32'h0, 4'b0100);
`endif

    // Back-to-back: four single-cycle ops on consecutive edges.
    bb_op[0] = 4'b0000; bb_a[0] = 32'd1;  bb_b[0] = 32'd2;      bb_exp[0] = 32'd3;
    bb_op[1] = 4'b0001; bb_a[1] = 32'd10; bb_b[1] = 32'd3;      bb_exp[1] = 32'd7;
    bb_op[2] = 4'b0011; bb_a[2] = 32'hF0; bb_b[2] = 32'h0F;     bb_exp[2] = 32'hFF;
    bb_op[3] = 4'b1001; bb_a[3] = 32'd9;  bb_b[3] = 32'h1234;   bb_exp[3] = 32'h1234;
    @(negedge CLK);
    ALUControl = bb_op[0]; Src_A = bb_a[0]; Src_B = bb_b[0]; Carry_In = 1'b0;
    In_Valid = 1'b1;
    check("b2b_ready0", {63'd0, In_Ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("b2b_valid%0d", i), {63'd0, Out_Valid}, 64'd1);
      check($sformatf("b2b_res%0d", i), {32'd0, ALUResult}, {32'd0, bb_exp[i]});
      check($sformatf("b2b_ready%0d", i + 1), {63'd0, In_Ready}, 64'd1);
      if (i < 3) begin
        ALUControl = bb_op[i+1]; Src_A = bb_a[i+1]; Src_B = bb_b[i+1];
      end else begin
        In_Valid = 1'b0;
      end
    end

    // Backpressure: result must hold and new inputs be ignored.
    @(negedge CLK);
    Out_Ready = 1'b0;
    run_op("eor", 4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 32'h0F0F_F0F0, 4'b0000);
    ALUControl = 4'b0000; Src_A = 32'd1; Src_B = 32'd1; In_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("bp_valid%0d", i), {63'd0, Out_Valid}, 64'd1);
      check($sformatf("bp_res%0d", i), {32'd0, ALUResult}, 64'h0F0F_F0F0);
      check($sformatf("bp_flags%0d", i), {60'd0, ALUFlags}, 64'd0);
      check($sformatf("bp_ready%0d", i), {63'd0, In_Ready}, 64'd0);
    end
    In_Valid = 1'b0; Out_Ready = 1'b1;
    @(negedge CLK);
    check("bp_release_idle", {63'd0, Out_Valid}, 64'd0);

`ifdef ALU_HS_MUL_EN
    // Multiply latency and result; operands changed during MUL must not matter.
    @(negedge CLK);
    ALUControl = 4'b1011; Src_A = 32'h0001_0003; Src_B = 32'h0002_0005; In_Valid = 1'b1;
    @(posedge CLK);
    #1 In_Valid = 1'b0; Src_A = 32'hDEAD_BEEF; Src_B = 32'h1; ALUControl = 4'b0000;
    n = 0;
    while (n < 100) begin
      @(posedge CLK);
      n++;
      #1;
      if (n == 1) check("mul_in_ready", {63'd0, In_Ready}, 64'd0);
      if (Out_Valid) break;
    end
    check("mul_latency", 64'(n), 64'd33);
    check("mul_res", {32'd0, ALUResult}, 64'h000B_000F);
    check("mul_flags", {60'd0, ALUFlags}, 64'd0);

    // Reset mid-multiply aborts without a result.
    @(negedge CLK);
    ALUControl = 4'b1011; Src_A = 32'd7; Src_B = 32'd9; In_Valid = 1'b1;
    @(posedge CLK);
    #1 In_Valid = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET_n = 1'b0;
    #1;
    check("mulrst_valid", {63'd0, Out_Valid}, 64'd0);
    check("mulrst_ready", {63'd0, In_Ready}, 64'd1);
    @(negedge CLK);
    RESET_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      seen = seen | Out_Valid;
    end
    check("mulrst_no_pulse", {63'd0, seen}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
